// File: rtl/mem_stage_lsu_if.sv
// Interface grouping the pipeline-side operands/results and the data-memory
// req/gnt/rvalid handshake of the memory-stage load/store unit.
`default_nettype none

interface mem_stage_lsu_if #(
    parameter int XLEN = 2
);
    localparam int W  = 1 << (XLEN + 4);
    localparam int NB = W / 8;

    logic          i_kill_m;
    logic [6:0]    i_opcode_m;
    logic [2:0]    i_f3_m;
    logic [W-1:0]  i_alu_out_m;
    logic [W-1:0]  i_store_data_m;
    logic          o_stall_m;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [W-1:0]  o_mem_addr;
    logic [NB-1:0] o_mem_be;
    logic [W-1:0]  o_mem_wdata;
    logic          i_mem_gnt;
    logic          i_mem_rvalid;
    logic [W-1:0]  i_mem_rdata;
    logic [W-1:0]  o_load_data_m;
    logic          o_load_valid_m;
    logic [3:0]    o_exception_code_m;
    logic [W-1:0]  o_bad_addr_m;

    modport master (
        input  i_kill_m, i_opcode_m, i_f3_m, i_alu_out_m, i_store_data_m,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_stall_m, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        output o_load_data_m, o_load_valid_m, o_exception_code_m, o_bad_addr_m
    );

    modport slave (
        output i_kill_m, i_opcode_m, i_f3_m, i_alu_out_m, i_store_data_m,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_stall_m, o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
        input  o_load_data_m, o_load_valid_m, o_exception_code_m, o_bad_addr_m
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one data-memory access per instruction,
// lane alignment, load extension, pipeline stall and access traps.
`default_nettype none

module mem_stage_lsu #(
    parameter int XLEN           = 2,   // 1 -> 32-bit, 2 -> 64-bit datapath
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    mem_stage_lsu_if.master bus
);
    localparam int W     = 1 << (XLEN + 4);
    localparam int NB    = W / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam bit HAS_D = (W == 64);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [W-1:0]   addr_q;
    logic [2:0]     f3_q;
    logic           store_q;
    logic [3:0]     exc_q;
    logic           req_q;
    logic           we_q;
    logic [W-1:0]   maddr_q;
    logic [NB-1:0]  be_q;
    logic [W-1:0]   wdata_q;
    logic [W-1:0]   ldata_q;

    logic           is_load;
    logic           is_store;
    logic           mem_op;
    logic           f3_legal;
    logic           misalign;
    logic           timeout_hit;
    logic [2:0]     size_mask;
    logic [OFFW-1:0] offset;
    logic [NB-1:0]  be_base;
    logic [NB-1:0]  be_next;
    logic [W-1:0]   wdata_next;
    logic [W-1:0]   lane;
    logic [W-1:0]   load_ext;

    assign is_load     = (bus.i_opcode_m == 7'b0000011);
    assign is_store    = (bus.i_opcode_m == 7'b0100011);
    assign mem_op      = is_load | is_store;
    assign offset      = bus.i_alu_out_m[OFFW-1:0];
    assign misalign    = |(bus.i_alu_out_m[2:0] & size_mask);
    assign timeout_hit = (count == CW'(TIMEOUT_CYCLES - 1));
    assign wdata_next  = bus.i_store_data_m << {offset, 3'b000};
    assign be_next     = is_store ? (be_base << offset) : '1;
    assign lane        = bus.i_mem_rdata >> {addr_q[OFFW-1:0], 3'b000};

    always_comb begin
        f3_legal = 1'b0;
        if (is_load) begin
            case (bus.i_f3_m)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal = 1'b1;
                3'd3, 3'd6:                   f3_legal = HAS_D;
                default:                      f3_legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (bus.i_f3_m)
                3'd0, 3'd1, 3'd2: f3_legal = 1'b1;
                3'd3:             f3_legal = HAS_D;
                default:          f3_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        size_mask = 3'b000;
        be_base   = '1;
        case (bus.i_f3_m[1:0])
            2'd0:    begin size_mask = 3'b000; be_base = NB'(1);  end
            2'd1:    begin size_mask = 3'b001; be_base = NB'(3);  end
            2'd2:    begin size_mask = 3'b011; be_base = NB'(15); end
            default: begin size_mask = 3'b111; be_base = '1;      end
        endcase
    end

    // Size casts of signed slices give the sign extension.
    always_comb begin
        load_ext = lane;
        case (f3_q)
            3'd0:    load_ext = W'($signed(lane[7:0]));
            3'd1:    load_ext = W'($signed(lane[15:0]));
            3'd2:    load_ext = W'($signed(lane[31:0]));
            3'd4:    load_ext = W'(lane[7:0]);
            3'd5:    load_ext = W'(lane[15:0]);
            3'd6:    load_ext = W'(lane[31:0]);
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            exc_q   <= 4'b1111;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op && !bus.i_kill_m) begin
                        addr_q  <= bus.i_alu_out_m;
                        f3_q    <= bus.i_f3_m;
                        store_q <= is_store;
                        if (!f3_legal) begin
                            exc_q <= 4'd2;
                            state <= S_ERR;
                        end else if (misalign) begin
                            exc_q <= is_store ? 4'd6 : 4'd4;
                            state <= S_ERR;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            maddr_q <= {bus.i_alu_out_m[W-1:OFFW], {OFFW{1'b0}}};
                            be_q    <= be_next;
                            wdata_q <= wdata_next;
                            count   <= '0;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A granted store is already committed, so kill cannot cancel it.
                    if (bus.i_mem_gnt && (store_q || !bus.i_kill_m)) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        count <= count + 1'b1;
                        state <= store_q ? S_DONE : S_RESP;
                    end else if (bus.i_kill_m) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        state <= S_IDLE;
                    end else if (timeout_hit) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        exc_q <= store_q ? 4'd7 : 4'd5;
                        state <= S_ERR;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_RESP: begin
                    // A kill coinciding with rvalid has nothing left to drain.
                    if (bus.i_kill_m) begin
                        count <= count + 1'b1;
                        state <= bus.i_mem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (bus.i_mem_rvalid) begin
                        ldata_q <= load_ext;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        exc_q <= 4'd5;
                        state <= S_ERR;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.i_mem_rvalid || timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The IDLE stall is gated by reset so every output is quiet while reset is held.
    always_comb begin
        case (state)
            S_IDLE:                 bus.o_stall_m = i_rst_n & mem_op & ~bus.i_kill_m;
            S_REQ, S_RESP, S_DRAIN: bus.o_stall_m = 1'b1;
            default:                bus.o_stall_m = 1'b0;
        endcase
    end

    assign bus.o_mem_req          = req_q;
    assign bus.o_mem_we           = we_q;
    assign bus.o_mem_addr         = maddr_q;
    assign bus.o_mem_be           = be_q;
    assign bus.o_mem_wdata        = wdata_q;
    assign bus.o_load_data_m      = ldata_q;
    assign bus.o_load_valid_m     = (state == S_DONE) & ~store_q & ~bus.i_kill_m;
    assign bus.o_exception_code_m = ((state == S_ERR) && !bus.i_kill_m) ? exc_q : 4'b1111;
    assign bus.o_bad_addr_m       = ((state == S_ERR) && !bus.i_kill_m) ? addr_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu (64-bit datapath, 16-cycle timeout).
`default_nettype none

module tb_mem_stage_lsu;
    localparam int XLEN = 2;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   stall_cnt;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.XLEN(XLEN)) bus ();

    mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT_CYCLES(16)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.i_kill_m       = 1'b0;
        bus.i_opcode_m     = 7'd0;
        bus.i_f3_m         = 3'd0;
        bus.i_alu_out_m    = '0;
        bus.i_store_data_m = '0;
        bus.i_mem_gnt      = 1'b0;
        bus.i_mem_rvalid   = 1'b0;
        bus.i_mem_rdata    = '0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sd);
        bus.i_opcode_m     = op;
        bus.i_f3_m         = f3;
        bus.i_alu_out_m    = addr;
        bus.i_store_data_m = sd;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] rdata, input logic [63:0] exp);
        stall_cnt = 0;
        issue(OP_LOAD, f3, addr, 64'd0);
        #1 stall_cnt += int'(bus.o_stall_m);
        cyc();
        bus.i_mem_gnt = 1'b1;
        #1 stall_cnt += int'(bus.o_stall_m);
        check({tag, "_req"}, 64'(bus.o_mem_req), 64'd1);
        check({tag, "_addr"}, bus.o_mem_addr, addr & ~64'h7);
        check({tag, "_be"}, 64'(bus.o_mem_be), 64'hFF);
        cyc();
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rdata;
        #1 stall_cnt += int'(bus.o_stall_m);
        cyc();
        bus.i_mem_rvalid = 1'b0;
        #1 stall_cnt += int'(bus.o_stall_m);
        check({tag, "_valid"}, 64'(bus.o_load_valid_m), 64'd1);
        check({tag, "_data"}, bus.o_load_data_m, exp);
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd3);
        bus.i_opcode_m = 7'd0;
        cyc();
        #1 check({tag, "_valid_pulse"}, 64'(bus.o_load_valid_m), 64'd0);
    endtask

    task automatic run_misalign(input string tag, input logic [6:0] op, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [3:0] code);
        issue(op, f3, addr, 64'd0);
        #1 check({tag, "_stall"}, 64'(bus.o_stall_m), 64'd1);
        cyc();
        #1;
        check({tag, "_noreq"}, 64'(bus.o_mem_req), 64'd0);
        check({tag, "_code"}, 64'(bus.o_exception_code_m), 64'(code));
        check({tag, "_bad_addr"}, bus.o_bad_addr_m, addr);
        check({tag, "_err_stall"}, 64'(bus.o_stall_m), 64'd0);
        bus.i_opcode_m = 7'd0;
        cyc();
        #1 check({tag, "_code_clear"}, 64'(bus.o_exception_code_m), 64'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) cyc();
        #1;
        check("rst_stall", 64'(bus.o_stall_m), 64'd0);
        check("rst_req", 64'(bus.o_mem_req), 64'd0);
        check("rst_code", 64'(bus.o_exception_code_m), 64'hF);
        check("rst_valid", 64'(bus.o_load_valid_m), 64'd0);
        rst_n = 1'b1;
        cyc();

        // LW: word at offset 4, sign-extended; then LB and LHU lane selection.
        run_load("lw", 3'd2, 64'h1004, 64'h8765_4321_DEAD_BEEF, 64'hFFFF_FFFF_8765_4321);
        run_load("lb", 3'd0, 64'h7005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("lhu", 3'd5, 64'h1006, 64'h8765_4321_DEAD_BEEF, 64'h0000_0000_0000_8765);

        // SB 0x2003
        issue(OP_STORE, 3'd0, 64'h2003, 64'hAB);
        cyc();
        bus.i_mem_gnt = 1'b1;
        #1;
        check("sb_req", 64'(bus.o_mem_req), 64'd1);
        check("sb_we", 64'(bus.o_mem_we), 64'd1);
        check("sb_addr", bus.o_mem_addr, 64'h2000);
        check("sb_be", 64'(bus.o_mem_be), 64'h08);
        check("sb_wdata", bus.o_mem_wdata, 64'h0000_0000_AB00_0000);
        cyc();
        bus.i_mem_gnt = 1'b0;
        #1;
        check("sb_done_stall", 64'(bus.o_stall_m), 64'd0);
        check("sb_done_req", 64'(bus.o_mem_req), 64'd0);
        check("sb_no_valid", 64'(bus.o_load_valid_m), 64'd0);
        bus.i_opcode_m = 7'd0;
        cyc();

        // SH at offset 6
        issue(OP_STORE, 3'd1, 64'h2006, 64'h1234);
        cyc();
        bus.i_mem_gnt = 1'b1;
        #1;
        check("sh_be", 64'(bus.o_mem_be), 64'hC0);
        check("sh_wdata", bus.o_mem_wdata, 64'h1234_0000_0000_0000);
        cyc();
        bus.i_mem_gnt  = 1'b0;
        bus.i_opcode_m = 7'd0;
        cyc();

        // Misaligned and illegal accesses
        run_misalign("lh_mis", OP_LOAD, 3'd1, 64'h3001, 4'd4);
        run_misalign("sw_mis", OP_STORE, 3'd2, 64'h3002, 4'd6);
        run_misalign("ill_f3", OP_LOAD, 3'd7, 64'h3000, 4'd2);

        // LD with no grant: 16 cycles in REQ, then load fault
        issue(OP_LOAD, 3'd3, 64'h4000, 64'd0);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            #1;
            if (i == 16) begin
                check("to_req_last", 64'(bus.o_mem_req), 64'd1);
                check("to_code_pending", 64'(bus.o_exception_code_m), 64'hF);
            end
        end
        cyc();
        #1;
        check("to_code", 64'(bus.o_exception_code_m), 64'd5);
        check("to_bad_addr", bus.o_bad_addr_m, 64'h4000);
        check("to_stall", 64'(bus.o_stall_m), 64'd0);
        check("to_req_drop", 64'(bus.o_mem_req), 64'd0);
        bus.i_opcode_m = 7'd0;
        cyc();
        #1 check("to_idle_code", 64'(bus.o_exception_code_m), 64'hF);

        // Kill during RESP, rvalid 3 cycles later
        issue(OP_LOAD, 3'd2, 64'h5000, 64'd0);
        cyc();
        bus.i_mem_gnt = 1'b1;
        cyc();
        bus.i_mem_gnt = 1'b0;
        bus.i_kill_m  = 1'b1;
        #1 check("kill_resp_stall", 64'(bus.o_stall_m), 64'd1);
        cyc();
        bus.i_kill_m   = 1'b0;
        bus.i_opcode_m = 7'd0;
        #1 check("kill_drain_stall", 64'(bus.o_stall_m), 64'd1);
        cyc();
        #1 check("kill_drain_stall2", 64'(bus.o_stall_m), 64'd1);
        cyc();
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 64'h1111_2222_3333_4444;
        #1;
        check("kill_rvalid_stall", 64'(bus.o_stall_m), 64'd1);
        check("kill_rvalid_valid", 64'(bus.o_load_valid_m), 64'd0);
        cyc();
        bus.i_mem_rvalid = 1'b0;
        #1;
        check("kill_after_stall", 64'(bus.o_stall_m), 64'd0);
        check("kill_after_valid", 64'(bus.o_load_valid_m), 64'd0);
        check("kill_data_kept", bus.o_load_data_m, 64'h0000_0000_0000_8765);

        // Async reset mid-RESP
        issue(OP_LOAD, 3'd2, 64'h6000, 64'd0);
        cyc();
        bus.i_mem_gnt = 1'b1;
        cyc();
        bus.i_mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_stall", 64'(bus.o_stall_m), 64'd0);
        check("arst_req", 64'(bus.o_mem_req), 64'd0);
        check("arst_be", 64'(bus.o_mem_be), 64'd0);
        check("arst_wdata", bus.o_mem_wdata, 64'd0);
        check("arst_ldata", bus.o_load_data_m, 64'd0);
        check("arst_code", 64'(bus.o_exception_code_m), 64'hF);
        check("arst_bad_addr", bus.o_bad_addr_m, 64'd0);
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        check("post_rst_stall", 64'(bus.o_stall_m), 64'd0);
        check("post_rst_req", 64'(bus.o_mem_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
